// File: rtl/add_sequencer_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// controller state encoding, slice width and the lookahead carry combine.
package add_sequencer_pkg;

    localparam int SLICE_W = 4;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_RUN  = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_RUN  = STATE_RUN,
        ST_DONE = STATE_DONE
    } state_t;

    // Carry out of a slice from its group generate/propagate and carry-in.
    function automatic logic carry_next(input logic g, input logic p, input logic c);
        return g | (p & c);
    endfunction

endpackage

// File: rtl/add_sequencer_cla_4.sv
// 4-bit carry-lookahead slice: nibble sum plus group generate/propagate
// so the caller forms the carry out itself.
module cla_4 (
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_carry,
    output logic [3:0] out_sum,
    output logic       out_generate,
    output logic       out_propogate
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [3:0] c_s;

    assign g_s = in_a & in_b;
    assign p_s = in_a ^ in_b;

    assign c_s[0] = in_carry;
    assign c_s[1] = g_s[0] | (p_s[0] & in_carry);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & in_carry);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & in_carry);

    assign out_sum       = p_s ^ c_s;
    assign out_generate  = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                         | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign out_propogate = &p_s;

endmodule

// File: rtl/add_sequencer.sv
// Nibble-serial WIDTH-bit adder/subtractor: one cla_4 slice is reused
// LSB-first for WIDTH/4 cycles; results become visible only on completion.
module add_sequencer
    import add_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_reset_n,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_sub,
    input  logic             in_carry,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int N  = WIDTH / SLICE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(N - 1);

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   x_r;
    logic [WIDTH-1:0]   y_r;
    logic [WIDTH-1:0]   result_r;
    logic               carry_r;

    logic [SLICE_W-1:0] x_nib_s;
    logic [SLICE_W-1:0] y_nib_s;
    logic [SLICE_W-1:0] nib_sum_s;
    logic               gen_s;
    logic               prop_s;
    logic               c_next_s;
    logic [WIDTH-1:0]   final_sum_s;

    cla_4 u_cla (
        .in_a          (x_nib_s),
        .in_b          (y_nib_s),
        .in_carry      (carry_r),
        .out_sum       (nib_sum_s),
        .out_generate  (gen_s),
        .out_propogate (prop_s)
    );

    // Select the active nibble and merge its sum into the running result.
    always_comb begin
        x_nib_s     = x_r[cnt_r*SLICE_W +: SLICE_W];
        y_nib_s     = y_r[cnt_r*SLICE_W +: SLICE_W];
        c_next_s    = carry_next(gen_s, prop_s, carry_r);
        final_sum_s = result_r;
        final_sum_s[cnt_r*SLICE_W +: SLICE_W] = nib_sum_s;
    end

    // Controller, datapath registers and registered status outputs.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            x_r          <= '0;
            y_r          <= '0;
            result_r     <= '0;
            carry_r      <= 1'b0;
            out_busy     <= 1'b0;
            out_done     <= 1'b0;
            out_sum      <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    out_done <= 1'b0;
                    if (in_start) begin
                        // Subtraction is x + ~y + 1, so only y and carry-in differ.
                        x_r      <= in_x;
                        y_r      <= in_sub ? ~in_y : in_y;
                        carry_r  <= in_sub ? 1'b1 : in_carry;
                        cnt_r    <= '0;
                        state_r  <= ST_RUN;
                        out_busy <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        out_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    result_r <= final_sum_s;
                    carry_r  <= c_next_s;
                    if (cnt_r == LAST_NIB) begin
                        state_r      <= ST_DONE;
                        out_busy     <= 1'b0;
                        out_done     <= 1'b1;
                        out_sum      <= final_sum_s;
                        out_carry    <= c_next_s;
                        out_overflow <= (x_r[WIDTH-1] == y_r[WIDTH-1]) &
                                        (final_sum_s[WIDTH-1] != x_r[WIDTH-1]);
                        out_zero     <= (final_sum_s == {WIDTH{1'b0}});
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    out_busy <= 1'b0;
                    out_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sequencer.sv
// Self-checking bench for add_sequencer: directed corners, busy/back-to-back,
// mid-run reset and random operations against an arithmetic reference.
module tb_add_sequencer;

    localparam int W = 32;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sub;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    logic         zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] exp_sum;
    logic         exp_carry;
    logic         exp_ovf;
    logic         exp_zero;

    always #5 clk = ~clk;

    add_sequencer #(.WIDTH(W)) dut (
        .in_clk       (clk),
        .in_reset_n   (rst_n),
        .in_start     (start),
        .in_x         (x),
        .in_y         (y),
        .in_sub       (sub),
        .in_carry     (cin),
        .out_busy     (busy),
        .out_done     (done),
        .out_sum      (sum),
        .out_carry    (co),
        .out_overflow (ovf),
        .out_zero     (zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the operands as given.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c);
        longint sa;
        longint sb;
        longint sr;
        longint maxv;
        longint minv;
        logic [W:0] full;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxv = (longint'(1) <<< (W - 1)) - longint'(1);
        minv = -(longint'(1) <<< (W - 1));
        if (s) begin
            exp_sum   = a - b;
            exp_carry = (a >= b);
            sr        = sa - sb;
        end else begin
            full      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            exp_sum   = full[W-1:0];
            exp_carry = full[W];
            sr        = sa + sb + longint'(c);
        end
        exp_ovf  = (sr > maxv) || (sr < minv);
        exp_zero = (exp_sum == {W{1'b0}});
    endtask

    task automatic check_results(input string tag);
        check({tag, "_sum"},   sum,  exp_sum);
        check({tag, "_carry"}, co,   exp_carry);
        check({tag, "_ovf"},   ovf,  exp_ovf);
        check({tag, "_zero"},  zero, exp_zero);
    endtask

    task automatic set_reset_expect();
        exp_sum   = '0;
        exp_carry = 1'b0;
        exp_ovf   = 1'b0;
        exp_zero  = 1'b1;
    endtask

    // One operation; glitch > 0 re-pulses start with junk operands in that RUN cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input int glitch, input string tag);
        @(negedge clk);
        start = 1'b1; x = a; y = b; sub = s; cin = c;
        @(posedge clk);
        for (int cyc = 1; cyc <= N; cyc++) begin
            @(negedge clk);
            check({tag, "_run_busy"}, busy, 1'b1);
            check({tag, "_run_done"}, done, 1'b0);
            check({tag, "_run_hold"}, sum,  exp_sum);
            if (cyc == 1) start = 1'b0;
            if (glitch != 0 && cyc == glitch) begin
                start = 1'b1; x = $urandom; y = $urandom; sub = 1'($urandom_range(0, 1));
            end else if (glitch != 0 && cyc == glitch + 1) begin
                start = 1'b0;
            end
        end
        model(a, b, s, c);
        @(negedge clk);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_done_busy"}, busy, 1'b0);
        check_results(tag);
        @(negedge clk);
        check({tag, "_after_done"}, done, 1'b0);
        check({tag, "_after_busy"}, busy, 1'b0);
        check_results({tag, "_held"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; x = '0; y = '0; sub = 1'b0; cin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        set_reset_expect();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check_results("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0000_0004, 32'h0000_0002, 1'b0, 1'b0, 0, "add_small");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "ripple");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "ovf_add");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 0, "sub_neg");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 0, "ovf_sub");
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 0, "sub_zero");
        run_op(32'h0FFF_FFFF, 32'hF000_0000, 1'b0, 1'b1, 0, "add_cin");
        run_op(32'h0000_00A5, 32'h0000_005A, 1'b0, 1'b0, 3, "start_ignored");

        // Back-to-back: start held high through DONE with new operands.
        @(negedge clk);
        start = 1'b1; x = 32'h0000_0010; y = 32'h0000_0020; sub = 1'b0; cin = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= N; cyc++) begin
            @(negedge clk);
            check("b2b_a_busy", busy, 1'b1);
            check("b2b_a_done", done, 1'b0);
            if (cyc == 1) begin
                x = 32'h8000_0000; y = 32'h8000_0000; sub = 1'b0; cin = 1'b0;
            end
        end
        model(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_a_done_pulse", done, 1'b1);
        check_results("b2b_a");
        @(negedge clk);
        check("b2b_b_busy_first", busy, 1'b1);
        check("b2b_b_done_first", done, 1'b0);
        start = 1'b0;
        for (int cyc = 2; cyc <= N; cyc++) begin
            @(negedge clk);
            check("b2b_b_busy", busy, 1'b1);
            check("b2b_b_done", done, 1'b0);
        end
        model(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_b_done_pulse", done, 1'b1);
        check_results("b2b_b");
        @(negedge clk);
        check("b2b_after", done, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; x = 32'h0000_1111; y = 32'h0000_2222; sub = 1'b0; cin = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            check("mid_busy", busy, 1'b1);
            if (cyc == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        set_reset_expect();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check_results("mid_rst");
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_nodone", done, 1'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            check("post_rst_idle_done", done, 1'b0);
            check("post_rst_idle_busy", busy, 1'b0);
        end
        run_op(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 0, "post_rst");

        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   0, "random");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
